// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and defaults for the data-memory responder
// Contents: FSM state enum, width/latency defaults, latency legal-range constants
//   and a helper used by the top to reject illegal LATENCY values.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam int DMEM_DATA_W      = 16;
  localparam int DMEM_ADDR_W      = 16;
  localparam int DMEM_AW          = 12;
  localparam int DMEM_LATENCY     = 4;
  localparam int DMEM_LATENCY_MIN = 1;
  localparam int DMEM_LATENCY_MAX = 15;

  function automatic bit latency_legal(input int lat);
    return (lat >= DMEM_LATENCY_MIN) && (lat <= DMEM_LATENCY_MAX);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - MEM-stage data-memory request/response bundle
// Signals: addr, sdata, re_mem, we_mem (CPU -> memory); ldata, rd_vld,
//   stall_mem (memory -> CPU). Modports: master = CPU side, slave = responder.
interface dmem_responder_if #(
  parameter int DATA_W = dmem_pkg::DMEM_DATA_W,
  parameter int ADDR_W = dmem_pkg::DMEM_ADDR_W
);

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] sdata;
  logic              re_mem;
  logic              we_mem;
  logic [DATA_W-1:0] ldata;
  logic              rd_vld;
  logic              stall_mem;

  modport master (
    output addr, sdata, re_mem, we_mem,
    input  ldata, rd_vld, stall_mem
  );

  modport slave (
    input  addr, sdata, re_mem, we_mem,
    output ldata, rd_vld, stall_mem
  );

endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port synchronous RAM, 2**AW x DATA_W, no reset
// Ports: clk; en (access enable); we (1 = write, 0 = read); addr; wdata;
//   rdata (registered read data, only updated by reads).
module dmem_array #(
  parameter int DATA_W = 16,
  parameter int AW     = 12
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder for the MEM stage
// Ports: clk; rst_n (asynchronous, active-low); bus (dmem_responder_if.slave:
//   addr/sdata/re_mem/we_mem in, ldata/rd_vld/stall_mem out).
// Optional feature macro: DMEM_WRITE_BUFFER_EN (one-entry posted write buffer).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W  = DMEM_DATA_W,
  parameter int ADDR_W  = DMEM_ADDR_W,
  parameter int AW      = DMEM_AW,
  parameter int LATENCY = DMEM_LATENCY
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_responder_if.slave bus
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  if (!latency_legal(LATENCY)) begin : g_latency_check
    $error("dmem_responder: LATENCY out of range 1..15");
  end

  dmem_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]     cap_addr_q;
  logic [DATA_W-1:0] cap_data_q;
  logic              cap_we_q;
  logic [DATA_W-1:0] ldata_q;
  logic              req, stall, accept, rd_vld;
  logic              ram_en, ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  // Upper address bits alias onto the implemented array.
  if (ADDR_W > AW) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[ADDR_W-1:AW];
  end

  // Gating with rst_n keeps stall_mem low and blocks any capture while in reset.
  assign req = rst_n & (bus.re_mem | bus.we_mem);

`ifdef DMEM_WRITE_BUFFER_EN
  logic              wb_vld_q;
  logic [CNT_W-1:0]  wb_cnt_q;
  logic [AW-1:0]     wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              post;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    accept  = 1'b0;
`ifdef DMEM_WRITE_BUFFER_EN
    post    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
`ifdef DMEM_WRITE_BUFFER_EN
          // Any request waits for a draining buffer; with it empty, writes post.
          if (wb_vld_q) begin
            stall = 1'b1;
          end else if (bus.we_mem) begin
            post = 1'b1;
          end else begin
            stall  = 1'b1;
            accept = 1'b1;
          end
`else
          stall  = 1'b1;
          accept = 1'b1;
`endif
        end
        if (accept) begin
          state_d = (LATENCY == 1) ? RESP : BUSY;
          cnt_d   = CNT_W'(LATENCY - 1);
        end
      end
      BUSY: begin
        stall = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Single RAM port: reads are issued in the accept cycle so data is ready by
  // RESP even at LATENCY=1; writes happen in RESP or on the last drain cycle.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = cap_addr_q;
    ram_wdata = cap_data_q;
    if (accept && !bus.we_mem) begin
      ram_en   = 1'b1;
      ram_addr = bus.addr[AW-1:0];
    end
    if (state_q == RESP && cap_we_q) begin
      ram_en = 1'b1;
      ram_we = 1'b1;
    end
`ifdef DMEM_WRITE_BUFFER_EN
    if (wb_vld_q && wb_cnt_q == CNT_W'(1)) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = wb_addr_q;
      ram_wdata = wb_data_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cap_addr_q <= '0;
      cap_data_q <= '0;
      cap_we_q   <= 1'b0;
      ldata_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        cap_addr_q <= bus.addr[AW-1:0];
        cap_data_q <= bus.sdata;
        cap_we_q   <= bus.we_mem;
      end
      if (rd_vld) begin
        ldata_q <= ram_rdata;
      end
    end
  end

`ifdef DMEM_WRITE_BUFFER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_vld_q  <= 1'b0;
      wb_cnt_q  <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else if (post) begin
      wb_vld_q  <= 1'b1;
      wb_cnt_q  <= CNT_W'(LATENCY);
      wb_addr_q <= bus.addr[AW-1:0];
      wb_data_q <= bus.sdata;
    end else if (wb_vld_q) begin
      wb_cnt_q <= wb_cnt_q - CNT_W'(1);
      if (wb_cnt_q == CNT_W'(1)) begin
        wb_vld_q <= 1'b0;
      end
    end
  end
`endif

  dmem_array #(
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // ldata shows the fresh RAM word during RESP, else the last loaded value.
  assign rd_vld        = (state_q == RESP) && !cap_we_q;
  assign bus.rd_vld    = rd_vld;
  assign bus.ldata     = rd_vld ? ram_rdata : ldata_q;
  assign bus.stall_mem = stall;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder (LATENCY 4 and 1)
module tb_dmem_responder;

`ifdef DMEM_WRITE_BUFFER_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif
  localparam int LAT = 4;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  logic [15:0] mem_model [0:4095];
  int          wb_busy_until;

  dmem_responder_if #(.DATA_W(16), .ADDR_W(16)) bus4 ();
  dmem_responder_if #(.DATA_W(16), .ADDR_W(16)) bus1 ();

  dmem_responder #(.DATA_W(16), .ADDR_W(16), .AW(12), .LATENCY(LAT)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  dmem_responder #(.DATA_W(16), .ADDR_W(16), .AW(4), .LATENCY(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transaction-level reference: a request seen in cycle c completes after a
  // number of stall cycles; the buffered build also waits out any drain.
  function automatic void model_req(input logic re, input logic we, input logic [15:0] a,
                                    input logic [15:0] d, input int c, output int es,
                                    output logic ev, output logic [15:0] ed);
    int idx;
    int start;
    idx = int'(a) % 4096;
    ev  = re && !we;
    ed  = ev ? mem_model[idx] : 16'h0;
    if (WB_EN) begin
      start = (c > wb_busy_until) ? c : wb_busy_until + 1;
      if (we) begin
        es = start - c;
        wb_busy_until = start + LAT;
      end else begin
        es = start - c + LAT;
      end
    end else begin
      es = LAT;
    end
    if (we) mem_model[idx] = d;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one request on bus4 (called at posedge+1), holds it while stalled.
  task automatic do_req(input logic re, input logic we, input logic [15:0] a, input logic [15:0] d,
                        output int stalls, output logic vld, output logic [15:0] data,
                        output logic early, output int c, output logic tmo);
    bit done;
    bus4.re_mem = re;
    bus4.we_mem = we;
    bus4.addr   = a;
    bus4.sdata  = d;
    stalls = 0;
    early  = 1'b0;
    vld    = 1'b0;
    data   = 16'h0;
    tmo    = 1'b1;
    c      = 0;
    done   = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      if (k == 0) c = cyc;
      if (bus4.stall_mem) begin
        stalls++;
        if (bus4.rd_vld) early = 1'b1;
      end else begin
        vld  = bus4.rd_vld;
        data = bus4.ldata;
        tmo  = 1'b0;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus4.re_mem = 1'b0;
    bus4.we_mem = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus4.re_mem = 1'b1; bus4.we_mem = 1'b0; bus4.addr = 16'h0010; bus4.sdata = 16'h0;
    bus1.re_mem = 1'b1; bus1.we_mem = 1'b0; bus1.addr = 16'h0001; bus1.sdata = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus4.stall_mem !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", bus4.stall_mem); end
    checks++; if (bus4.rd_vld !== 1'b0) begin errors++; $display("FAIL reset_rd_vld got %b exp 0", bus4.rd_vld); end
    checks++; if (bus4.ldata !== 16'h0) begin errors++; $display("FAIL reset_ldata got %h exp 0000", bus4.ldata); end
    checks++; if (bus1.stall_mem !== 1'b0) begin errors++; $display("FAIL reset_stall_l1 got %b exp 0", bus1.stall_mem); end
    @(posedge clk); #1;
    bus4.re_mem = 1'b0; bus1.re_mem = 1'b0;
    rst_n = 1'b1;
    wb_busy_until = -1000;
    idle(1);
  endtask

  task automatic test_read_latency();
    int st, es, c; logic v, e, t, ev; logic [15:0] dq, ed;
    do_req(1'b0, 1'b1, 16'h0010, 16'hBEEF, st, v, dq, e, c, t);
    model_req(1'b0, 1'b1, 16'h0010, 16'hBEEF, c, es, ev, ed);
    checks++; if (t || st != es) begin errors++; $display("FAIL wr10_stalls got %0d exp %0d tmo %b", st, es, t); end
    idle(LAT + 1);
    do_req(1'b1, 1'b0, 16'h0010, 16'h0, st, v, dq, e, c, t);
    model_req(1'b1, 1'b0, 16'h0010, 16'h0, c, es, ev, ed);
    checks++; if (t || st != es) begin errors++; $display("FAIL rd10_stalls got %0d exp %0d tmo %b", st, es, t); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL rd10_early_vld got %b exp 0", e); end
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL rd10_vld got %b exp 1", v); end
    checks++; if (dq !== 16'hBEEF) begin errors++; $display("FAIL rd10_data got %h exp beef", dq); end
  endtask

  task automatic test_write_then_read();
    int st, es, c; logic v, e, t, ev; logic [15:0] dq, ed;
    do_req(1'b0, 1'b1, 16'h0020, 16'h1234, st, v, dq, e, c, t);
    model_req(1'b0, 1'b1, 16'h0020, 16'h1234, c, es, ev, ed);
    checks++; if (t || st != es || v !== 1'b0) begin errors++; $display("FAIL wr20 stalls %0d exp %0d vld %b", st, es, v); end
    do_req(1'b1, 1'b0, 16'h0020, 16'h0, st, v, dq, e, c, t);
    model_req(1'b1, 1'b0, 16'h0020, 16'h0, c, es, ev, ed);
    checks++; if (t || st != es) begin errors++; $display("FAIL rd20_stalls got %0d exp %0d", st, es); end
    checks++; if (v !== 1'b1 || dq !== 16'h1234) begin errors++; $display("FAIL rd20 vld %b data %h exp 1 1234", v, dq); end
  endtask

  task automatic test_reset_mid_write();
    int st, es, c; logic v, e, t, ev; logic [15:0] dq, ed;
    do_req(1'b0, 1'b1, 16'h0030, 16'h1111, st, v, dq, e, c, t);
    model_req(1'b0, 1'b1, 16'h0030, 16'h1111, c, es, ev, ed);
    idle(LAT + 2);
    bus4.we_mem = 1'b1; bus4.addr = 16'h0030; bus4.sdata = 16'hAAAA;
    idle(2);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (bus4.stall_mem !== 1'b0 || bus4.rd_vld !== 1'b0) begin errors++; $display("FAIL midrst stall %b vld %b exp 0 0", bus4.stall_mem, bus4.rd_vld); end
    @(posedge clk); #1;
    bus4.we_mem = 1'b0;
    @(negedge clk);
    checks++; if (bus4.stall_mem !== 1'b0 || bus4.rd_vld !== 1'b0) begin errors++; $display("FAIL midrst2 stall %b vld %b exp 0 0", bus4.stall_mem, bus4.rd_vld); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    wb_busy_until = -1000;
    idle(1);
    do_req(1'b1, 1'b0, 16'h0030, 16'h0, st, v, dq, e, c, t);
    model_req(1'b1, 1'b0, 16'h0030, 16'h0, c, es, ev, ed);
    checks++; if (t || v !== 1'b1 || dq !== 16'h1111) begin errors++; $display("FAIL rd30_after_reset vld %b data %h exp 1 1111", v, dq); end
  endtask

  task automatic test_conflict_alias();
    int st, es, c; logic v, e, t, ev; logic [15:0] dq, ed;
    do_req(1'b1, 1'b1, 16'hF040, 16'h5555, st, v, dq, e, c, t);
    model_req(1'b1, 1'b1, 16'hF040, 16'h5555, c, es, ev, ed);
    checks++; if (t || st != es) begin errors++; $display("FAIL conflict_stalls got %0d exp %0d", st, es); end
    checks++; if (e !== 1'b0 || v !== 1'b0) begin errors++; $display("FAIL conflict_vld early %b end %b exp 0 0", e, v); end
    do_req(1'b1, 1'b0, 16'h0040, 16'h0, st, v, dq, e, c, t);
    model_req(1'b1, 1'b0, 16'h0040, 16'h0, c, es, ev, ed);
    checks++; if (t || st != es || v !== 1'b1 || dq !== 16'h5555) begin errors++; $display("FAIL alias40 stalls %0d vld %b data %h exp %0d 1 5555", st, v, dq, es); end
  endtask

  task automatic test_latency1();
    int st; logic v, e; logic [15:0] dq; bit done;
    bus1.we_mem = 1'b1; bus1.addr = 16'h0003; bus1.sdata = 16'hA5A5;
    st = 0; done = 1'b0;
    for (int k = 0; k < 16 && !done; k++) begin
      @(negedge clk);
      if (bus1.stall_mem) st++; else done = 1'b1;
      @(posedge clk); #1;
    end
    bus1.we_mem = 1'b0;
    checks++; if (!done || st != (WB_EN ? 0 : 1)) begin errors++; $display("FAIL l1_write_stalls got %0d exp %0d", st, WB_EN ? 0 : 1); end
    idle(3);
    bus1.re_mem = 1'b1; bus1.addr = 16'h0003;
    st = 0; done = 1'b0; e = 1'b0; v = 1'b0; dq = 16'h0;
    for (int k = 0; k < 16 && !done; k++) begin
      @(negedge clk);
      if (bus1.stall_mem) begin st++; if (bus1.rd_vld) e = 1'b1; end
      else begin v = bus1.rd_vld; dq = bus1.ldata; done = 1'b1; end
      @(posedge clk); #1;
    end
    bus1.re_mem = 1'b0;
    checks++; if (!done || st != 1 || e !== 1'b0) begin errors++; $display("FAIL l1_read_stalls got %0d early %b exp 1 0", st, e); end
    checks++; if (v !== 1'b1 || dq !== 16'hA5A5) begin errors++; $display("FAIL l1_read vld %b data %h exp 1 a5a5", v, dq); end
  endtask

`ifdef DMEM_WRITE_BUFFER_EN
  task automatic test_write_buffer();
    int st, es, c; logic v, e, t, ev; logic [15:0] dq, ed;
    idle(LAT + 2);
    do_req(1'b0, 1'b1, 16'h0050, 16'h7777, st, v, dq, e, c, t);
    model_req(1'b0, 1'b1, 16'h0050, 16'h7777, c, es, ev, ed);
    checks++; if (t || st != 0) begin errors++; $display("FAIL wb_post_stalls got %0d exp 0", st); end
    do_req(1'b1, 1'b0, 16'h0050, 16'h0, st, v, dq, e, c, t);
    model_req(1'b1, 1'b0, 16'h0050, 16'h0, c, es, ev, ed);
    checks++; if (t || st != 2 * LAT) begin errors++; $display("FAIL wb_read_stalls got %0d exp %0d", st, 2 * LAT); end
    checks++; if (v !== 1'b1 || dq !== 16'h7777) begin errors++; $display("FAIL wb_read vld %b data %h exp 1 7777", v, dq); end
  endtask
`endif

  task automatic test_random();
    int st, es, c, op; logic v, e, t, ev, re, we; logic [15:0] dq, ed, a, d;
    logic [11:0] pool [8];
    for (int i = 0; i < 8; i++) begin
      pool[i] = 12'($urandom_range(0, 4095));
      a = {4'($urandom_range(0, 15)), pool[i]};
      d = 16'($urandom);
      do_req(1'b0, 1'b1, a, d, st, v, dq, e, c, t);
      model_req(1'b0, 1'b1, a, d, c, es, ev, ed);
      checks++; if (t || st != es || v !== 1'b0) begin errors++; $display("FAIL rnd_init%0d stalls %0d exp %0d vld %b", i, st, es, v); end
    end
    for (int n = 0; n < 40; n++) begin
      idle($urandom_range(0, 2));
      op = $urandom_range(0, 2);
      re = (op != 1);
      we = (op != 0);
      a  = {4'($urandom_range(0, 15)), pool[$urandom_range(0, 7)]};
      d  = 16'($urandom);
      do_req(re, we, a, d, st, v, dq, e, c, t);
      model_req(re, we, a, d, c, es, ev, ed);
      checks++; if (t || st != es) begin errors++; $display("FAIL rnd%0d_stalls got %0d exp %0d tmo %b", n, st, es, t); end
      checks++; if (e !== 1'b0 || v !== ev) begin errors++; $display("FAIL rnd%0d_vld early %b end %b exp 0 %b", n, e, v, ev); end
      if (ev) begin
        checks++; if (dq !== ed) begin errors++; $display("FAIL rnd%0d_data addr %h got %h exp %h", n, a, dq, ed); end
      end
    end
  endtask

  initial begin
    cyc = 0;
    checks = 0;
    errors = 0;
    wb_busy_until = -1000;
    bus4.re_mem = 1'b0; bus4.we_mem = 1'b0; bus4.addr = 16'h0; bus4.sdata = 16'h0;
    bus1.re_mem = 1'b0; bus1.we_mem = 1'b0; bus1.addr = 16'h0; bus1.sdata = 16'h0;
    test_reset();
    test_read_latency();
    test_write_then_read();
    test_reset_mid_write();
    test_conflict_alias();
    test_latency1();
`ifdef DMEM_WRITE_BUFFER_EN
    test_write_buffer();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
